// File: rtl/pipe_line_pkg.sv
// Shared definitions for the 3-stage pipeline control slice.
// Contents:
//   state_e     - stall/handshake sequencer states
//   NopInsn     - encoding loaded into a pipeline register as a bubble (addi x0, x0, 0)
//   RaWDefault  - default register-address width
package pipe_line_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StLdUse = 2'd2,
        StErr   = 2'd3
    } state_e;

    localparam logic [31:0] NopInsn    = 32'h0000_0013;
    localparam int unsigned RaWDefault = 5;

endpackage

// File: rtl/pipe_line_hazard_cmp.sv
// Load-use hazard comparator (purely combinational).
// Ports:
//   is_load_i            - producing instruction is a load
//   reg_wr_i             - producing instruction writes rd
//   rd_i                 - producing instruction destination register
//   rs1_i, rs2_i         - consuming instruction source registers
//   use_rs1_i, use_rs2_i - consuming instruction actually reads rs1/rs2
//   hazard_o             - consumer needs the loaded value one cycle too early
module pipe_line_hazard_cmp #(
    parameter int unsigned RA_W = 5
) (
    input  logic            is_load_i,
    input  logic            reg_wr_i,
    input  logic [RA_W-1:0] rd_i,
    input  logic [RA_W-1:0] rs1_i,
    input  logic            use_rs1_i,
    input  logic [RA_W-1:0] rs2_i,
    input  logic            use_rs2_i,
    output logic            hazard_o
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = use_rs1_i && (rs1_i == rd_i);
    assign rs2_match = use_rs2_i && (rs2_i == rd_i);

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    assign hazard_o = is_load_i && reg_wr_i && (rd_i != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_line_stall_ctrl.sv
// Hazard and data-memory handshake sequencer for a 3-stage pipeline.
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   mem_rd_i/mem_wr_i       - memory-stage instruction is a load/store
//   reg_wr_mem_i, rd_mem_i  - memory-stage instruction writes rd
//   rs1/rs2_ex_i, use_*     - execute-stage source registers and their use flags
//   br_taken_ex_i           - execute-stage branch resolved taken
//   dmem_ack_i, dmem_err_i  - memory completion / bus error
//   err_clr_i               - clears err_sticky_o
//   dmem_req_o, dmem_we_o   - access request and write enable
//   stall_front_o           - hold PC and fetch->execute register
//   hold_mem_o              - hold execute->memory register
//   bubble_mem_o            - load NOP into execute->memory register
//   flush_if_o              - replace fetched instruction with NOP
//   trap_o                  - one-cycle pulse on abandoned access
//   err_sticky_o            - sticky bus/timeout error
//   stall_cnt_o             - saturating count of stall_front_o cycles
module pipe_line_stall_ctrl
    import pipe_line_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned RA_W    = RaWDefault,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mem_rd_i,
    input  logic             mem_wr_i,
    input  logic             reg_wr_mem_i,
    input  logic [RA_W-1:0]  rd_mem_i,
    input  logic [RA_W-1:0]  rs1_ex_i,
    input  logic [RA_W-1:0]  rs2_ex_i,
    input  logic             use_rs1_ex_i,
    input  logic             use_rs2_ex_i,
    input  logic             br_taken_ex_i,
    input  logic             dmem_ack_i,
    input  logic             dmem_err_i,
    input  logic             err_clr_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic             stall_front_o,
    output logic             hold_mem_o,
    output logic             bubble_mem_o,
    output logic             flush_if_o,
    output logic             trap_o,
    output logic             err_sticky_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [15:0]      tmo_q, tmo_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic access;
    logic hazard;
    logic done;
    logic req, stall, hold, bubble, trap, err_flush;

    assign access = mem_rd_i | mem_wr_i;
    assign done   = dmem_ack_i & ~dmem_err_i;

    pipe_line_hazard_cmp #(
        .RA_W(RA_W)
    ) u_hazard_cmp (
        .is_load_i (mem_rd_i),
        .reg_wr_i  (reg_wr_mem_i),
        .rd_i      (rd_mem_i),
        .rs1_i     (rs1_ex_i),
        .use_rs1_i (use_rs1_ex_i),
        .rs2_i     (rs2_ex_i),
        .use_rs2_i (use_rs2_ex_i),
        .hazard_o  (hazard)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Error outranks completion; timeout only when no ack arrived.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    if (dmem_err_i)       state_d = StErr;
                    else if (!dmem_ack_i) state_d = StWait;
                    else if (hazard)      state_d = StLdUse;
                end
            end
            StWait: begin
                if (dmem_err_i)            state_d = StErr;
                else if (dmem_ack_i)       state_d = hazard ? StLdUse : StIdle;
                else if (tmo_q == TmoLast) state_d = StErr;
            end
            StLdUse: state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode, before reset gating.
    always_comb begin
        req       = 1'b0;
        stall     = 1'b0;
        hold      = 1'b0;
        bubble    = 1'b0;
        trap      = 1'b0;
        err_flush = 1'b0;
        unique case (state_q)
            StIdle: begin
                req = access;
                if (access && !dmem_err_i) begin
                    if (!dmem_ack_i) begin
                        stall = 1'b1;
                        hold  = 1'b1;
                    end else if (hazard) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end
                end
            end
            StWait: begin
                // Registered-state decode only: ack never feeds back into req here.
                req = 1'b1;
                if (done) begin
                    if (hazard) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                    hold  = 1'b1;
                end
            end
            StLdUse: ;
            StErr: begin
                trap      = 1'b1;
                bubble    = 1'b1;
                err_flush = 1'b1;
            end
            default: ;
        endcase
    end

    // Gate with reset so the request drops as soon as reset asserts, even with access high.
    assign dmem_req_o    = reset & req;
    assign dmem_we_o     = reset & req & mem_wr_i;
    assign stall_front_o = reset & stall;
    assign hold_mem_o    = reset & hold;
    assign bubble_mem_o  = reset & bubble;
    assign trap_o        = reset & trap;
    // A branch held by a stall flushes in the cycle the stall releases.
    assign flush_if_o    = reset & ((br_taken_ex_i & ~stall) | err_flush);
    assign err_sticky_o  = err_sticky_q;
    assign stall_cnt_o   = stall_cnt_q;

    // Timeout counter, error flag and stall counter.
    always_comb begin
        tmo_d = 16'd0;
        if (state_q == StWait && !dmem_ack_i && !dmem_err_i && tmo_q != TmoLast) begin
            tmo_d = tmo_q + 16'd1;
        end

        err_sticky_d = err_sticky_q;
        if (state_q == StErr)  err_sticky_d = 1'b1;
        else if (err_clr_i)    err_sticky_d = 1'b0;

        stall_cnt_d = stall_cnt_q;
        if (stall_front_o && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_q        <= 16'd0;
            err_sticky_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            tmo_q        <= tmo_d;
            err_sticky_q <= err_sticky_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_line_stall_ctrl.sv
// Bench for pipe_line_stall_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_pipe_line_stall_ctrl;
    import pipe_line_pkg::*;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned RA_W    = 5;
    localparam int unsigned CNT_W   = 6;
    localparam int          CntMax  = (1 << CNT_W) - 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            mem_rd, mem_wr, reg_wr;
    logic [RA_W-1:0] rd, rs1, rs2;
    logic            use_rs1, use_rs2, br, ack, err, clr;

    logic             dmem_req, dmem_we, stall_front, hold_mem, bubble_mem;
    logic             flush_if, trap, err_sticky;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    pipe_line_stall_ctrl #(
        .TIMEOUT(TIMEOUT),
        .RA_W   (RA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_rd_i      (mem_rd),
        .mem_wr_i      (mem_wr),
        .reg_wr_mem_i  (reg_wr),
        .rd_mem_i      (rd),
        .rs1_ex_i      (rs1),
        .rs2_ex_i      (rs2),
        .use_rs1_ex_i  (use_rs1),
        .use_rs2_ex_i  (use_rs2),
        .br_taken_ex_i (br),
        .dmem_ack_i    (ack),
        .dmem_err_i    (err),
        .err_clr_i     (clr),
        .dmem_req_o    (dmem_req),
        .dmem_we_o     (dmem_we),
        .stall_front_o (stall_front),
        .hold_mem_o    (hold_mem),
        .bubble_mem_o  (bubble_mem),
        .flush_if_o    (flush_if),
        .trap_o        (trap),
        .err_sticky_o  (err_sticky),
        .stall_cnt_o   (stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model ----------------
    // Tracks the outstanding access as "busy for age cycles", plus two one-shot
    // cycles: the post-bubble idle cycle and the trap cycle.
    bit m_busy, m_after_bubble, m_trap_cycle, m_sticky;
    int m_age, m_cnt;

    logic e_req, e_we, e_stall, e_hold, e_bubble, e_flush, e_trap;

    function automatic bit load_use(input logic ld, input logic wr_rd, input logic [RA_W-1:0] d,
                                    input logic u1, input logic [RA_W-1:0] s1,
                                    input logic u2, input logic [RA_W-1:0] s2);
        return ld && wr_rd && (d != 0) && ((u1 && s1 == d) || (u2 && s2 == d));
    endfunction

    always_comb begin
        e_req = 0; e_we = 0; e_stall = 0; e_hold = 0; e_bubble = 0; e_flush = 0; e_trap = 0;
        if (reset) begin
            if (m_trap_cycle) begin
                e_trap = 1; e_flush = 1; e_bubble = 1;
            end else begin
                if (!m_after_bubble && (m_busy || mem_rd || mem_wr)) begin
                    e_req = 1;
                    e_we  = mem_wr;
                    if (!m_busy && err) begin
                        // fresh access failing immediately: goes straight to trap
                    end else if (!(ack && !err)) begin
                        e_stall = 1; e_hold = 1;
                    end else if (load_use(mem_rd, reg_wr, rd, use_rs1, rs1, use_rs2, rs2)) begin
                        e_stall = 1; e_bubble = 1;
                    end
                end
                e_flush = br && !e_stall;
            end
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 0; m_after_bubble <= 0; m_trap_cycle <= 0; m_sticky <= 0;
            m_age <= 0; m_cnt <= 0;
        end else begin
            m_after_bubble <= 0;
            m_trap_cycle   <= 0;
            if (!m_trap_cycle && !m_after_bubble && (m_busy || mem_rd || mem_wr)) begin
                if (err) begin
                    m_busy <= 0; m_trap_cycle <= 1;
                end else if (ack) begin
                    m_busy <= 0;
                    m_after_bubble <= load_use(mem_rd, reg_wr, rd, use_rs1, rs1, use_rs2, rs2);
                end else if (m_busy && m_age == TIMEOUT - 1) begin
                    m_busy <= 0; m_trap_cycle <= 1;
                end else begin
                    m_age  <= m_busy ? m_age + 1 : 0;
                    m_busy <= 1;
                end
            end
            if (m_trap_cycle) m_sticky <= 1;
            else if (clr)     m_sticky <= 0;
            if (e_stall && m_cnt < CntMax) m_cnt <= m_cnt + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (started) begin
            chk("req",        32'(dmem_req),    32'(e_req));
            chk("we",         32'(dmem_we),     32'(e_we));
            chk("stall",      32'(stall_front), 32'(e_stall));
            chk("hold",       32'(hold_mem),    32'(e_hold));
            chk("bubble",     32'(bubble_mem),  32'(e_bubble));
            chk("flush",      32'(flush_if),    32'(e_flush));
            chk("trap",       32'(trap),        32'(e_trap));
            chk("sticky",     32'(err_sticky),  32'(m_sticky));
            chk("stall_cnt",  32'(stall_cnt),   32'(m_cnt));
        end
    end

    // ---------------- Stimulus ----------------
    task automatic idle_in();
        mem_rd = 0; mem_wr = 0; reg_wr = 0; rd = 0; rs1 = 0; rs2 = 0;
        use_rs1 = 0; use_rs2 = 0; br = 0; ack = 0; err = 0; clr = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        idle_in();
        $display("tb: bubble encoding %08h", NopInsn);
        #1 reset = 1'b0;
        #1 started = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        settle();
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_sticky", 32'(err_sticky), 0);

        // Zero-wait load, no dependency.
        step(); idle_in(); mem_rd = 1; reg_wr = 1; rd = 5; use_rs1 = 1; rs1 = 6; ack = 1; settle();
        chk("t1_req", 32'(dmem_req), 1);
        chk("t1_stall", 32'(stall_front), 0);
        chk("t1_bubble", 32'(bubble_mem), 0);
        step(); idle_in(); settle();
        chk("t1_cnt", 32'(stall_cnt), 0);

        // Store acked on the fourth cycle.
        step(); mem_wr = 1; settle();
        chk("t2_we", 32'(dmem_we), 1);
        chk("t2_stall", 32'(stall_front), 1);
        chk("t2_hold", 32'(hold_mem), 1);
        for (int i = 0; i < 2; i++) begin
            step(); settle();
            chk("t2_wait_stall", 32'(stall_front), 1);
        end
        step(); ack = 1; settle();
        chk("t2_ack_req", 32'(dmem_req), 1);
        chk("t2_ack_stall", 32'(stall_front), 0);
        chk("t2_ack_hold", 32'(hold_mem), 0);
        step(); idle_in(); settle();
        chk("t2_cnt", 32'(stall_cnt), 3);

        // Load rd=7 acked after two cycles, execute reads rs2=7.
        step(); mem_rd = 1; reg_wr = 1; rd = 7; use_rs2 = 1; rs2 = 7; settle();
        chk("t3_hold", 32'(hold_mem), 1);
        step(); settle();
        step(); ack = 1; settle();
        chk("t3_stall", 32'(stall_front), 1);
        chk("t3_bubble", 32'(bubble_mem), 1);
        chk("t3_hold_off", 32'(hold_mem), 0);
        step(); idle_in(); settle();
        chk("t3_lduse_stall", 32'(stall_front), 0);
        chk("t3_lduse_bubble", 32'(bubble_mem), 0);
        // rd = x0 variant.
        step(); mem_rd = 1; reg_wr = 1; rd = 0; use_rs2 = 1; rs2 = 0; settle();
        step(); settle();
        step(); ack = 1; settle();
        chk("t3_x0_bubble", 32'(bubble_mem), 0);
        chk("t3_x0_stall", 32'(stall_front), 0);
        step(); idle_in(); settle();
        chk("t3_cnt", 32'(stall_cnt), 8);

        // Timeout with TIMEOUT=4.
        step(); mem_rd = 1; settle();
        for (int i = 0; i < 4; i++) begin
            step(); settle();
            chk("t4_wait_stall", 32'(stall_front), 1);
        end
        step(); settle();
        chk("t4_trap", 32'(trap), 1);
        chk("t4_flush", 32'(flush_if), 1);
        chk("t4_bubble", 32'(bubble_mem), 1);
        chk("t4_req", 32'(dmem_req), 0);
        step(); idle_in(); settle();
        chk("t4_trap_off", 32'(trap), 0);
        chk("t4_sticky", 32'(err_sticky), 1);
        chk("t4_cnt", 32'(stall_cnt), 13);
        step(); clr = 1; settle();
        chk("t4_sticky_hold", 32'(err_sticky), 1);
        step(); idle_in(); settle();
        chk("t4_sticky_clr", 32'(err_sticky), 0);

        // Branch during a two-cycle wait.
        step(); mem_wr = 1; br = 1; settle();
        chk("t5_flush_a", 32'(flush_if), 0);
        step(); settle();
        chk("t5_flush_b", 32'(flush_if), 0);
        step(); ack = 1; settle();
        chk("t5_flush_rel", 32'(flush_if), 1);
        // Error together with ack takes the error path.
        step(); idle_in(); mem_rd = 1; reg_wr = 1; rd = 3; use_rs1 = 1; rs1 = 3; ack = 1; err = 1;
        settle();
        chk("t5_err_bubble", 32'(bubble_mem), 0);
        step(); idle_in(); settle();
        chk("t5_err_trap", 32'(trap), 1);
        step(); settle();
        chk("t5_err_sticky", 32'(err_sticky), 1);

        // Asynchronous reset in the middle of a wait.
        step(); mem_wr = 1; settle();
        step(); settle();
        chk("t6_pre_stall", 32'(stall_front), 1);
        #1 reset = 1'b0;
        #1;
        chk("t6_req_drop", 32'(dmem_req), 0);
        chk("t6_stall_drop", 32'(stall_front), 0);
        chk("t6_cnt_clr", 32'(stall_cnt), 0);
        chk("t6_sticky_clr", 32'(err_sticky), 0);
        #2 idle_in();
        reset = 1'b1;
        step(); settle();
        chk("t6_post_req", 32'(dmem_req), 0);
        chk("t6_post_cnt", 32'(stall_cnt), 0);
        chk("t6_post_trap", 32'(trap), 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            step();
            idle_in();
            case ($urandom_range(0, 3))
                0: mem_rd = 1;
                1: mem_wr = 1;
                default: ;
            endcase
            reg_wr  = 1'($urandom_range(0, 1));
            rd      = RA_W'($urandom_range(0, 3));
            rs1     = RA_W'($urandom_range(0, 3));
            rs2     = RA_W'($urandom_range(0, 3));
            use_rs1 = 1'($urandom_range(0, 1));
            use_rs2 = 1'($urandom_range(0, 1));
            br      = ($urandom_range(0, 4) == 0);
            ack     = ($urandom_range(0, 9) < 4);
            err     = ($urandom_range(0, 19) == 0);
            clr     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #1 reset = 1'b0;
                #2 reset = 1'b1;
            end
        end
        step(); idle_in();
        repeat (2) @(posedge clock);
        #2;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_line_stall_ctrl.md
Name: pipe_line_stall_ctrl

Overview:
Hazard and memory-handshake sequencer for the 3-stage pipeline (fetch, decode/execute, memory/writeback). It drives the data-memory request/acknowledge handshake for the instruction in the memory stage, and holds the front of the pipe while a variable-latency access is outstanding. It also inserts one-cycle load-use bubbles into the execute→memory pipeline register and generates branch and trap flushes. A sticky error flag and a stall-cycle counter expose bus health.

Parameters:
TIMEOUT, 255, max cycles in WAIT before the access is abandoned (1..65535)
RA_W, 5, register-address width
CNT_W, 32, stall-cycle counter width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_rd_i  in  1  memory-stage instruction is a load
mem_wr_i  in  1  memory-stage instruction is a store
reg_wr_mem_i  in  1  memory-stage instruction writes rd
rd_mem_i  in  RA_W  memory-stage destination register
rs1_ex_i, rs2_ex_i  in  RA_W  execute-stage source registers
use_rs1_ex_i, use_rs2_ex_i  in  1  execute-stage instruction reads rs1/rs2
br_taken_ex_i  in  1  branch/jump resolved taken in execute
dmem_ack_i  in  1  memory completes the access this cycle
dmem_err_i  in  1  bus error, valid with or without ack
err_clr_i  in  1  clears err_sticky_o
dmem_req_o  out  1  access request
dmem_we_o  out  1  request is a store
stall_front_o  out  1  hold PC and fetch→execute register
hold_mem_o  out  1  hold execute→memory register contents
bubble_mem_o  out  1  load NOP (0x00000013) into execute→memory register
flush_if_o  out  1  replace fetched instruction with NOP
trap_o  out  1  one-cycle pulse on abandoned access
err_sticky_o  out  1  sticky bus/timeout error
stall_cnt_o  out  CNT_W  saturating count of cycles with stall_front_o=1

Behaviour:
- Reset (reset=0, asynchronous) forces state IDLE, timeout counter 0, err_sticky_o=0, stall_cnt_o=0, and all outputs 0. dmem_req_o drops in the same cycle as reset assertion, without waiting for a clock edge. An access in flight at reset is dropped silently.
- access = mem_rd_i | mem_wr_i. dmem_we_o = mem_wr_i whenever dmem_req_o=1.
- States: IDLE, WAIT, LDUSE, ERR.
- IDLE:
  - dmem_req_o = access (combinational).
  - access & dmem_ack_i & ~dmem_err_i: zero-wait completion, no stall. Then check load-use.
  - access & ~dmem_ack_i: go WAIT. stall_front_o=1 and hold_mem_o=1 in this cycle.
  - access & dmem_err_i: go ERR.
- WAIT:
  - dmem_req_o=1, stall_front_o=1, hold_mem_o=1. The counter increments every cycle.
  - dmem_ack_i & ~dmem_err_i: stall outputs drop this cycle, counter clears. Then check load-use.
  - dmem_err_i, or counter reaches TIMEOUT-1 without ack: go ERR.
- Load-use check (on completing cycle of a load):
  - Condition: mem_rd_i & reg_wr_mem_i & rd_mem_i≠0 & ((use_rs1_ex_i & rs1_ex_i==rd_mem_i) | (use_rs2_ex_i & rs2_ex_i==rd_mem_i)).
  - If true, assert stall_front_o=1 and bubble_mem_o=1 in the completing cycle, then go LDUSE. Otherwise return to IDLE.
- LDUSE: all outputs 0 for exactly one cycle, then IDLE. It never re-triggers on the same load, because the bubble has already advanced.
- ERR (one cycle):
  - trap_o=1, flush_if_o=1, bubble_mem_o=1, dmem_req_o=0.
  - err_sticky_o sets on the next edge. Counter clears. Next state IDLE.
- flush_if_o = br_taken_ex_i & ~stall_front_o, OR'd with the ERR flush. A branch held by a stall flushes in the cycle the stall releases.
- Priority: reset > ERR > WAIT hold > load-use bubble > branch flush.
- err_sticky_o: set wins over err_clr_i in the same cycle.
- stall_cnt_o: +1 per stall_front_o cycle, saturates at all-ones.
- No combinational path from dmem_ack_i to dmem_req_o in WAIT. The request stays high until the ack cycle.

Decomposition:
- Shared package pipe_line_pkg: state enum (IDLE, WAIT, LDUSE, ERR), NOP constant 32'h00000013, RA_W default.
- One sub-module, pipe_line_hazard_cmp: combinational load-use comparator, reused by any future forwarding unit.
- FSM, timeout counter and stall counter stay in the top module.

Test Plan:
- Zero-wait load (rd=5) with ack same cycle, execute reads x6 → no stall, no bubble, stall_cnt_o=0.
- Store with ack 3 cycles after request → dmem_req_o, dmem_we_o, stall_front_o, hold_mem_o all high 3 cycles and drop on the ack cycle; stall_cnt_o=3.
- Load rd=7, ack after 2 cycles, execute uses rs2=7 → 2 hold cycles, then 1 cycle stall_front_o and bubble_mem_o, then LDUSE idle cycle; rd=0 variant → no bubble.
- TIMEOUT=4, no ack → 4 WAIT cycles, then trap_o, flush_if_o and bubble_mem_o pulse for 1 cycle; err_sticky_o=1 until err_clr_i.
- br_taken_ex_i asserted during a 2-cycle WAIT → flush_if_o=0 while stalled, then 1 on release cycle; dmem_err_i with ack → ERR path taken, not completion.
- reset pulled low mid-WAIT, asynchronous to clock → dmem_req_o and stall_front_o fall before the next edge; all outputs and counters are 0 after release.
